// File: rtl/pipe_hazard_ctrl.sv
// Stage-register sequencer for a 5-stage pipeline: load-use interlock, branch squash, memory freeze, HALT drain/restart.
// Define PIPE_STALL_CNT_EN to build the saturating stall-cycle counter on stall_cnt.
module pipe_hazard_ctrl #(
   parameter int LOAD_LAT     = 1,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       rs_id,
   input  logic [2:0]       rt_id,
   input  logic             use_rs_id,
   input  logic             use_rt_id,
   input  logic             from_main_mem_ex,
   input  logic             regwrite_ex,
   input  logic [2:0]       regwrite_adr_ex,
   input  logic             branch_taken_ex,
   input  logic             is_halt_ex,
   input  logic             mem_busy,
   input  logic             restart,
   output logic             pc_en,
   output logic             en_ifid,
   output logic             flush_ifid,
   output logic             en_idex,
   output logic             flush_idex,
   output logic             en_exmem,
   output logic             en_memwb,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } state_t;

   // The lu_haz cycle itself is the first bubble, so LU_STALL covers the remaining LOAD_LAT-1.
   localparam logic [2:0] LU_CNT_INIT    = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;
   localparam logic [2:0] DRAIN_CNT_INIT = 3'(DRAIN_CYCLES - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] cnt_r;
   logic [2:0] cnt_nxt_s;
   logic       lu_haz_s;
   logic       freeze_s;

   function automatic logic src_match(input logic use_src, input logic [2:0] src,
                                      input logic [2:0] dst);
      return use_src && (src == dst);
   endfunction

   assign lu_haz_s = from_main_mem_ex && regwrite_ex &&
                     (src_match(use_rs_id, rs_id, regwrite_adr_ex) ||
                      src_match(use_rt_id, rt_id, regwrite_adr_ex));
   assign freeze_s = mem_busy && (state_r != HALTED);

   // State and bubble/drain counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RUN;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state and counter decode; a memory freeze holds everything.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (freeze_s) begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
      end else begin
         case (state_r)
            RUN: begin
               if (branch_taken_ex) begin
                  state_nxt_s = RUN;
               end else if (is_halt_ex) begin
                  state_nxt_s = DRAIN;
                  cnt_nxt_s   = DRAIN_CNT_INIT;
               end else if (lu_haz_s) begin
                  if (LOAD_LAT > 1) begin
                     state_nxt_s = LU_STALL;
                     cnt_nxt_s   = LU_CNT_INIT;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else begin
                  state_nxt_s = RUN;
               end
            end
            LU_STALL: begin
               if (cnt_r == 3'd0) begin
                  state_nxt_s = RUN;
               end else begin
                  cnt_nxt_s = cnt_r - 3'd1;
               end
            end
            DRAIN: begin
               if (cnt_r == 3'd0) begin
                  state_nxt_s = HALTED;
               end else begin
                  cnt_nxt_s = cnt_r - 3'd1;
               end
            end
            HALTED: begin
               if (restart) begin
                  state_nxt_s = RUN;
                  cnt_nxt_s   = 3'd0;
               end else begin
                  state_nxt_s = HALTED;
               end
            end
            default: begin
               state_nxt_s = RUN;
               cnt_nxt_s   = 3'd0;
            end
         endcase
      end
   end

   // Stage-register control decode from state and current inputs.
   always_comb begin
      pc_en      = 1'b1;
      en_ifid    = 1'b1;
      flush_ifid = 1'b0;
      en_idex    = 1'b1;
      flush_idex = 1'b0;
      en_exmem   = 1'b1;
      en_memwb   = 1'b1;
      halted     = 1'b0;
      if (freeze_s) begin
         pc_en    = 1'b0;
         en_ifid  = 1'b0;
         en_idex  = 1'b0;
         en_exmem = 1'b0;
         en_memwb = 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (branch_taken_ex) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else if (is_halt_ex || lu_haz_s) begin
                  pc_en      = 1'b0;
                  en_ifid    = 1'b0;
                  flush_idex = 1'b1;
               end else begin
                  pc_en = 1'b1;
               end
            end
            LU_STALL, DRAIN: begin
               pc_en      = 1'b0;
               en_ifid    = 1'b0;
               flush_idex = 1'b1;
            end
            HALTED: begin
               halted   = 1'b1;
               en_exmem = 1'b0;
               en_memwb = 1'b0;
               if (restart) begin
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
               end else begin
                  pc_en   = 1'b0;
                  en_ifid = 1'b0;
                  en_idex = 1'b0;
               end
            end
            default: begin
               pc_en = 1'b1;
            end
         endcase
      end
   end

`ifdef PIPE_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;

   // Saturating count of non-HALTED cycles with the PC held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else if (!pc_en && (state_r != HALTED) && (stall_cnt_r != {CNT_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`else
   assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Decides every cycle which stage registers advance, hold or are flushed.
- Covers load-use interlocks, taken-branch squashes, external memory wait and HALT drain/restart.
- Sits beside the core datapath; its outputs drive the PC enable and the en_*/flush_* inputs of the stage registers.

Parameters:
- LOAD_LAT, 1, bubble cycles inserted on a load-use hazard (1..7).
- DRAIN_CYCLES, 2, cycles after a HALT leaves EX before the core is frozen (1..7).
- CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_id  in  3  source register A of the instruction in ID.
- rt_id  in  3  source register B of the instruction in ID.
- use_rs_id  in  1  ID instruction reads rs_id.
- use_rt_id  in  1  ID instruction reads rt_id.
- from_main_mem_ex  in  1  EX instruction is a load.
- regwrite_ex  in  1  EX instruction writes a register.
- regwrite_adr_ex  in  3  destination register of the EX instruction.
- branch_taken_ex  in  1  branch resolved taken in EX this cycle.
- is_halt_ex  in  1  HALT is in EX.
- mem_busy  in  1  main memory not ready; freezes the pipe.
- restart  in  1  single-cycle pulse that leaves HALTED.
- pc_en  out  1  PC load enable.
- en_ifid  out  1  IF/ID enable.
- flush_ifid  out  1  IF/ID clear.
- en_idex  out  1  ID/EX enable.
- flush_idex  out  1  ID/EX clear (bubble insertion).
- en_exmem  out  1  EX/MEM enable.
- en_memwb  out  1  MEM/WB enable.
- halted  out  1  core frozen after HALT.
- stall_cnt  out  CNT_W  stall-cycle count (optional feature).

Behaviour:
- Architecture:
  - States: RUN, LU_STALL, DRAIN, HALTED.
  - Down-counter cnt (3 bits).
  - State and cnt are registered; outputs decode combinationally from state and inputs.
- Reset (reset=0, async):
  - state=RUN, cnt=0, stall_cnt=0.
  - Outputs therefore take RUN values: all en_*=1, pc_en=1, flushes=0, halted=0.
- Load-use hazard, lu_haz = from_main_mem_ex & regwrite_ex & ((use_rs_id & rs_id==regwrite_adr_ex) | (use_rt_id & rt_id==regwrite_adr_ex)).
- Freeze: mem_busy=1 in any state except HALTED →
  - all en_* and pc_en =0, flushes=0.
  - state and cnt hold.
  - Freeze has top priority.
- RUN, default: all enables 1, flushes 0.
- RUN, priority order when not frozen:
  1. branch_taken_ex → flush_ifid=1, flush_idex=1, pc_en=1; stay RUN. lu_haz and is_halt_ex are ignored; the branch squashes those instructions.
  2. is_halt_ex → pc_en=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1; next state DRAIN, cnt=DRAIN_CYCLES-1.
  3. lu_haz → pc_en=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1. If LOAD_LAT==1 stay RUN; else next state LU_STALL, cnt=LOAD_LAT-2.
- LU_STALL:
  - Same outputs as the lu_haz cycle.
  - cnt==0 → RUN; else cnt-1.
  - lu_haz is not re-evaluated here.
  - branch_taken_ex cannot occur (EX holds a bubble).
- DRAIN:
  - pc_en=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1.
  - cnt==0 → HALTED; else cnt-1.
- HALTED:
  - All en_*=0, pc_en=0, halted=1.
  - mem_busy is ignored.
  - restart=1 → flush_ifid=1, flush_idex=1, pc_en=1, en_ifid=1, en_idex=1; next state RUN.
- restart outside HALTED is ignored.
- Total bubble count for a load-use hazard is exactly LOAD_LAT.
- Async reset mid-LU_STALL or mid-DRAIN returns to RUN immediately. No partial drain is remembered.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 every cycle where pc_en=0 and state!=HALTED. Freeze, LU_STALL, lu_haz and DRAIN cycles all count.
  - Saturates at all-ones.
  - Cleared only by reset.
- Undefined: stall_cnt tied to 0; no counter flops.

Test Plan:
- Load-use, LOAD_LAT=1: load to r3 in EX, rs_id=3, use_rs_id=1 → exactly one cycle with pc_en=0, en_ifid=0, flush_idex=1; RUN next cycle.
- Load-use, LOAD_LAT=3: same stimulus → 3 consecutive bubble cycles, then pc_en=1. mem_busy=1 for 2 cycles during the 2nd bubble stretches the stall to 5 cycles total, all en_*=0 during the busy cycles.
- Branch beats hazard: branch_taken_ex=1 with lu_haz=1 and is_halt_ex=1 in the same cycle → flush_ifid=flush_idex=1, pc_en=1; state stays RUN.
- Halt, DRAIN_CYCLES=2: is_halt_ex → 1 entry cycle + 2 DRAIN cycles → halted=1. restart pulse → 1 cycle with both flushes and pc_en=1 → halted=0.
- Reset mid-DRAIN: reset low in the 1st DRAIN cycle → outputs immediately return to the RUN pattern; stall_cnt=0; halted never rises.
- PIPE_STALL_CNT_EN, CNT_W=4: hold mem_busy=1 for 20 cycles → stall_cnt saturates at 15.
